// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared types and constants for the RV32M multiply/divide unit.
//   mul_op_t  - multiplier opcode (MUL, MULH, MULHSU, MULHU)
//   div_op_t  - divider opcode (DIV, DIVU, REM, REMU)
//   state_t   - multiplier FSM state encoding (IDLE, BUSY, DONE)
//   MUL_STEPS - number of shift-add steps per multiply
package rv32m_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam logic [5:0] MUL_STEPS = 6'd32;

endpackage

// File: rtl/divider_32bit.sv
// divider_32bit: combinational 32-bit divide/remainder.
//   div_opcode    - DIV, DIVU, REM, REMU
//   operand1      - dividend
//   operand2      - divisor
//   result_divide - quotient or remainder, zero latency
// Unrolled restoring division on magnitudes, then sign fix-up; divide by
// zero and signed overflow are overridden explicitly.
module divider_32bit
    import rv32m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      div_opcode,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic [XLEN-1:0] result_divide
);

    logic            is_signed, is_rem;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] quo_s, rem_s;
    logic [XLEN-1:0] min_neg;

    always_comb begin
        is_signed = (div_opcode == OP_DIV) || (div_opcode == OP_REM);
        is_rem    = (div_opcode == OP_REM) || (div_opcode == OP_REMU);
        a_neg     = is_signed && operand1[XLEN-1];
        b_neg     = is_signed && operand2[XLEN-1];
        a_mag     = a_neg ? (~operand1 + 1'b1) : operand1;
        b_mag     = b_neg ? (~operand2 + 1'b1) : operand2;
        min_neg   = {1'b1, {(XLEN-1){1'b0}}};

        // Partial remainder is one bit wider so the compare never overflows.
        rem = '0;
        quo = '0;
        for (int i = XLEN-1; i >= 0; i--) begin
            rem = {rem[XLEN-1:0], a_mag[i]};
            if (rem >= {1'b0, b_mag}) begin
                rem    = rem - {1'b0, b_mag};
                quo[i] = 1'b1;
            end
        end

        // Quotient truncates toward zero; remainder follows the dividend.
        quo_s = (a_neg ^ b_neg) ? (~quo + 1'b1) : quo;
        rem_s = a_neg ? (~rem[XLEN-1:0] + 1'b1) : rem[XLEN-1:0];

        if (operand2 == '0) begin
            result_divide = is_rem ? operand1 : '1;
        end else if (is_signed && (operand1 == min_neg) && (operand2 == '1)) begin
            result_divide = is_rem ? '0 : min_neg;
        end else begin
            result_divide = is_rem ? rem_s : quo_s;
        end
    end

endmodule

// File: rtl/multiplier_iterative.sv
// multiplier_iterative: radix-2 shift-add 32x32 multiplier, 64-bit result.
//   clk, rst        - clock, asynchronous active-low reset
//   start_e         - start request, sampled only in IDLE
//   mul_opcode      - selects operand signedness
//   operand1/2      - multiplicand / multiplier, captured on start
//   mul_use         - holds DONE (and the product) while high
//   result_multiply - sign-corrected 64-bit product, registered on DONE entry
//   ready           - high while in DONE
module multiplier_iterative
    import rv32m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_e,
    input  logic [1:0]        mul_opcode,
    input  logic [XLEN-1:0]   operand1,
    input  logic [XLEN-1:0]   operand2,
    input  logic              mul_use,
    output logic [2*XLEN-1:0] result_multiply,
    output logic              ready
);

    state_t            state;
    logic [5:0]        cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic              neg;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;

    // Operand1 is signed for everything but MULHU; operand2 only for MUL/MULH.
    // Only the product sign needs to survive capture, so the opcode itself
    // is folded into neg rather than stored.
    always_comb begin
        a_neg = (mul_opcode != OP_MULHU) && operand1[XLEN-1];
        b_neg = ((mul_opcode == OP_MUL) || (mul_opcode == OP_MULH)) && operand2[XLEN-1];
        a_mag = a_neg ? (~operand1 + 1'b1) : operand1;
        b_mag = b_neg ? (~operand2 + 1'b1) : operand2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            cnt             <= '0;
            acc             <= '0;
            mcand           <= '0;
            mplier          <= '0;
            neg             <= 1'b0;
            result_multiply <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_e) begin
                        mcand  <= {{XLEN{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        neg    <= a_neg ^ b_neg;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    // The edge after the last step moves to DONE and
                    // publishes the product in one go.
                    if (cnt == MUL_STEPS) begin
                        result_multiply <= neg ? (~acc + 1'b1) : acc;
                        state           <= DONE;
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 6'd1;
                    end
                end
                DONE: begin
                    if (!mul_use) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready = (state == DONE);

endmodule

// File: rtl/rv32m_muldiv.sv
// rv32m_muldiv: RV32M execute-stage arithmetic unit.
//   clk, rst        - clock, asynchronous active-low reset
//   startE          - multiply request (sampled in IDLE)
//   mul_opcode      - MUL/MULH/MULHSU/MULHU
//   div_opcode      - DIV/DIVU/REM/REMU
//   operand1/2      - rs1 / rs2
//   mul_use         - keep a completed product presented
//   result_multiply - 64-bit product, registered
//   ready           - product valid
//   result_divide   - combinational quotient / remainder
module rv32m_muldiv
    import rv32m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              startE,
    input  logic [1:0]        mul_opcode,
    input  logic [1:0]        div_opcode,
    input  logic [XLEN-1:0]   operand1,
    input  logic [XLEN-1:0]   operand2,
    input  logic              mul_use,
    output logic [2*XLEN-1:0] result_multiply,
    output logic              ready,
    output logic [XLEN-1:0]   result_divide
);

    multiplier_iterative #(.XLEN(XLEN)) u_mul (
        .clk             (clk),
        .rst             (rst),
        .start_e         (startE),
        .mul_opcode      (mul_opcode),
        .operand1        (operand1),
        .operand2        (operand2),
        .mul_use         (mul_use),
        .result_multiply (result_multiply),
        .ready           (ready)
    );

    divider_32bit #(.XLEN(XLEN)) u_div (
        .div_opcode    (div_opcode),
        .operand1      (operand1),
        .operand2      (operand2),
        .result_divide (result_divide)
    );

endmodule

// File: tb/tb_rv32m_muldiv.sv
// tb_rv32m_muldiv: directed and random checks of rv32m_muldiv against a
// plain-arithmetic reference model.
module tb_rv32m_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        startE;
    logic [1:0]  mul_opcode;
    logic [1:0]  div_opcode;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        mul_use;
    logic [63:0] result_multiply;
    logic        ready;
    logic [31:0] result_divide;

    int n_tests = 0;
    int n_fail  = 0;

    rv32m_muldiv #(.XLEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .startE          (startE),
        .mul_opcode      (mul_opcode),
        .div_opcode      (div_opcode),
        .operand1        (operand1),
        .operand2        (operand2),
        .mul_use         (mul_use),
        .result_multiply (result_multiply),
        .ready           (ready),
        .result_divide   (result_divide)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] mul_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = (op == 2'b11) ? {32'h0, a} : {{32{a[31]}}, a};
        eb = (op == 2'b00 || op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;   // low 64 bits of the extended product
    endfunction

    function automatic logic [31:0] div_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'h0) return (op[1]) ? a : 32'hFFFF_FFFF;
        case (op)
            2'b00: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
            2'b01: return a / b;
            2'b10: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        div_opcode = op;
        operand1   = a;
        operand2   = b;
        #1;
        check(tag, {32'h0, result_divide}, {32'h0, exp});
    endtask

    // Start a multiply, scramble inputs after capture, optionally poke a
    // second start mid-BUSY, measure latency and check result and ready width.
    task automatic run_mul(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input bit poke, input bit hold);
        int lat;
        mul_use    = hold;
        startE     = 1'b1;
        mul_opcode = op;
        operand1   = a;
        operand2   = b;
        @(posedge clk);              // E0
        #1;
        startE     = 1'b0;
        operand1   = $urandom;
        operand2   = $urandom;
        mul_opcode = 2'($urandom);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (ready) break;
            if (poke && lat == 5) begin
                startE   = 1'b1;
                operand1 = $urandom;
                operand2 = $urandom;
            end else begin
                startE = 1'b0;
            end
        end
        startE = 1'b0;
        check({tag, "_lat"}, 64'(lat), 64'd33);
        check({tag, "_res"}, result_multiply, exp);
        if (hold) begin
            repeat (4) begin
                @(posedge clk);
                #1;
                check({tag, "_hold_rdy"}, {63'h0, ready}, 64'd1);
                check({tag, "_hold_res"}, result_multiply, exp);
            end
            mul_use = 1'b0;
        end
        @(posedge clk);
        #1;
        check({tag, "_rdy_drop"}, {63'h0, ready}, 64'd0);
        check({tag, "_res_kept"}, result_multiply, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;

        rst        = 1'b0;
        startE     = 1'b0;
        mul_opcode = 2'b00;
        div_opcode = 2'b00;
        operand1   = 32'h0;
        operand2   = 32'h0;
        mul_use    = 1'b0;
        #12;
        check("reset_ready", {63'h0, ready}, 64'd0);
        check("reset_result", result_multiply, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // divider directed
        chk_div("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        chk_div("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        chk_div("divu_m7_2",  2'b01, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
        chk_div("remu_m7_2",  2'b11, 32'hFFFF_FFF9, 32'd2, 32'h1);
        chk_div("div_by0",    2'b00, 32'h1234, 32'h0, 32'hFFFF_FFFF);
        chk_div("divu_by0",   2'b01, 32'h1234, 32'h0, 32'hFFFF_FFFF);
        chk_div("rem_by0",    2'b10, 32'h1234, 32'h0, 32'h1234);
        chk_div("remu_by0",   2'b11, 32'h1234, 32'h0, 32'h1234);
        chk_div("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        chk_div("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        chk_div("divu_ovfop", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        chk_div("rem_7_m3",   2'b10, 32'd7, 32'hFFFF_FFFD, 32'd1);

        // divider random against the model
        for (int i = 0; i < 300; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: b = -($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            chk_div("div_rand", op, a, b, div_ref(op, a, b));
        end

        // multiplier directed
        @(posedge clk);
        #1;
        run_mul("mul_7_m3",     2'b00, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0);
        run_mul("mulh_min_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
        run_mul("mulhu_ff",     2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0);
        run_mul("mulhsu_ff",    2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001, 1'b0, 1'b0);
        run_mul("mul_hold",     2'b01, 32'h1234_5678, 32'h9ABC_DEF0,
                mul_ref(2'b01, 32'h1234_5678, 32'h9ABC_DEF0), 1'b0, 1'b1);
        run_mul("mul_poke",     2'b10, 32'hDEAD_BEEF, 32'h0000_0003,
                mul_ref(2'b10, 32'hDEAD_BEEF, 32'h0000_0003), 1'b1, 1'b0);

        // reset in the middle of BUSY
        startE     = 1'b1;
        mul_opcode = 2'b00;
        operand1   = 32'd5;
        operand2   = 32'd9;
        @(posedge clk);
        #1;
        startE = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_ready", {63'h0, ready}, 64'd0);
        check("rst_mid_result", result_multiply, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_after_ready", {63'h0, ready}, 64'd0);
        run_mul("mul_after_rst", 2'b00, 32'd5, 32'd9, 64'd45, 1'b0, 1'b0);

        // multiplier random against the model
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            if (i % 6 == 0) a = 32'h8000_0000;
            if (i % 6 == 1) b = 32'h0;
            run_mul("mul_rand", op, a, b, mul_ref(op, a, b), 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32m_muldiv.md
# rv32m_muldiv

RV32M arithmetic unit for the execute stage of the 5-stage pipeline. Contains an iterative 32×32 multiplier (MUL, MULH, MULHSU, MULHU), producing a 64-bit product after a fixed multi-cycle latency, and a purely combinational 32-bit divider/remainder unit (DIV, DIVU, REM, REMU). The surrounding M-extension check logic selects the 32-bit half or result, drives operands from the forwarded sources, and stalls on `ready`.

## Interface
Parameters:
- `XLEN`, 32: operand width; only 32 is supported.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `startE` in 1: request a multiply; sampled only in IDLE.
- `mul_opcode` in 2: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `div_opcode` in 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `operand1` in 32: rs1 (multiplicand / dividend).
- `operand2` in 32: rs2 (multiplier / divisor).
- `mul_use` in 1: hold request; keeps a completed product presented.
- `result_multiply` out 64: full product, registered.
- `ready` out 1: product valid.
- `result_divide` out 32: quotient or remainder, combinational.

## Operation
- Multiplier FSM states: IDLE, BUSY, DONE.
  - IDLE: on `startE` = 1, latch `operand1`, `operand2` and `mul_opcode`, clear the 6-bit counter, go to BUSY.
  - BUSY: one radix-2 shift-add step per cycle on operand magnitudes; after 32 steps go to DONE.
  - DONE: register the sign-corrected product into `result_multiply`. Go to IDLE when `mul_use` = 0; stay in DONE while `mul_use` = 1.
- Signedness:
  - MUL and MULH: both operands signed.
  - MULHSU: `operand1` signed, `operand2` unsigned.
  - MULHU: both operands unsigned.
  - The product is negated when exactly one signed-interpreted operand is negative. The full 64-bit two's-complement result is always produced; the caller selects [31:0] for MUL and [63:32] for the others.
- Operand or opcode changes during BUSY or DONE have no effect. `startE` outside IDLE is ignored.
- If `startE` is still high on return to IDLE, a new multiply starts.
- Divider, combinational:
  - Signed ops truncate toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return `operand1`.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
  - Implemented as an unrolled restoring divide on magnitudes, with sign fix-up and the special cases above.

## Timing
- Reset (asynchronous, `rst` low): state IDLE, `ready` = 0, `result_multiply` = 0, counter = 0. Reset mid-operation aborts the multiply with no partial result.
- Operands are captured at edge E0 (IDLE with `startE` high). BUSY occupies edges E1..E32. DONE is entered at E33, with `result_multiply` valid from that edge.
- `ready` = (state == DONE): it rises 33 cycles after E0 and is high for exactly one cycle when `mul_use` = 0.
- `result_multiply` holds its value until the next DONE entry or reset.
- `result_divide` is valid in the same cycle as its inputs, with zero cycles of latency and no dependence on `ready`.

## Structure
- Package `rv32m_pkg` holds:
  - the `mul_op_t` and `div_op_t` 2-bit enums with the encodings above;
  - the FSM `state_t` (IDLE/BUSY/DONE);
  - the `MUL_STEPS` = 32 constant.
- Sub-modules:
  - `multiplier_iterative`: sequential part, with FSM, counter and accumulator.
  - `divider_32bit`: combinational part.
- The top level only wires the two sub-modules.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), `startE` pulsed for one cycle → `ready` high exactly 33 cycles later, one cycle wide; `result_multiply` = 0xFFFFFFFF_FFFFFFEB.
- MULH 0x80000000 × 0x80000000 → [63:32] = 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE_00000001. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF_00000001.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. DIVU → 0x7FFFFFFC. REMU → 1.
- Divide by zero with `operand1` = 0x1234 → DIV/DIVU return 0xFFFFFFFF, REM/REMU return 0x1234. Overflow 0x80000000 / 0xFFFFFFFF → DIV 0x80000000, REM 0.
- `mul_use` = 1 at completion → `ready` stays high and the result is held; `mul_use` dropped → IDLE next cycle. A second `startE` during BUSY is ignored.
- `rst` low at BUSY step 10 → immediate IDLE, `ready` = 0, `result_multiply` = 0. A fresh start afterwards completes normally in 33 cycles.
